tdm_demux8: RTL
===============

Name: tdm_demux8

Overview:
- Receive end of the time-division serial channel whose transmit side is built from the MUX4_1/MUX8_1 selectors.
- Takes one WIDTH-bit sample per valid cycle, with a frame_start marker on slot 0.
- Steers each sample to its channel register using an internal slot counter, which acts as the demux select.
- Presents a complete frame atomically on a parallel output bus, and flags framing errors.

Parameters:
- WIDTH, 1: bits per sample.
- NCH, 8: channels (slots) per frame; must be a power of two, 2..16.
- SEL_W, $clog2(NCH): slot counter width. Derived; do not override.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- din  in  WIDTH  serial sample for the current slot.
- din_valid  in  1  din carries a sample this cycle.
- frame_start  in  1  qualified by din_valid; the sample is slot 0 of a new frame.
- dout  out  NCH*WIDTH  last complete frame; channel k at bits [k*WIDTH +: WIDTH].
- frame_done  out  1  one-cycle pulse: dout updated this cycle.
- sync_err  out  1  one-cycle pulse: frame_start arrived before the frame completed.
- locked  out  1  high while aligned to a frame.
- sel  out  SEL_W  slot index the next valid sample will be written to.

Behaviour:
- Reset (async assert, sync deassert by the source):
  - state=HUNT; sel=0; dout=0; shadow=0.
  - frame_done=0; sync_err=0; locked=0.
- Shadow register: NCH x WIDTH bits, written per slot. dout is loaded from the shadow only on frame completion, so it never shows a partial frame.
- State HUNT:
  - Valid samples without frame_start are discarded; sel stays 0.
  - din_valid&frame_start: write din to shadow[0]; sel<=1; go LOCKED; locked<=1 on the same edge.
- State LOCKED, on din_valid & !frame_start:
  - Write shadow[sel]; sel<=sel+1 (wraps mod NCH).
  - If sel==NCH-1:
    - dout <= {din, shadow[NCH-2:0]}, so the final sample goes straight to the output and needs no extra cycle.
    - frame_done<=1 for one cycle.
    - sel wraps to 0.
    - Stay LOCKED; the next sample is expected with frame_start.
- State LOCKED, on din_valid & frame_start:
  - sel==0: normal frame start. Write shadow[0]; sel<=1.
  - sel!=0: short frame. sync_err<=1 for one cycle; the partial frame is discarded (dout unchanged); write shadow[0]; sel<=1; stay LOCKED.
- State LOCKED, sel==0 with din_valid & !frame_start: missing marker.
  - sync_err<=1; go HUNT; locked<=0; sample discarded; sel stays 0.
- din_valid=0: no state change; sel holds. Gaps of any length inside a frame are legal.
- Latency: frame_done and the new dout appear on the clock edge that samples slot NCH-1 (registered outputs, visible the cycle after).
- rst mid-frame: everything returns to reset values immediately; no frame_done is emitted for the partial frame.
- frame_done and sync_err are never asserted in the same cycle.

Optional Feature:
- Macro: TDM_DEMUX_ERR_CNT_EN.
- Defined:
  - Extra output port err_cnt, 8 bits.
  - Increments on every sync_err pulse and saturates at 8'hFF.
  - Cleared only by rst.
- Undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Package tdm_pkg holds:
  - state encoding: HUNT=1'b0, LOCKED=1'b1;
  - localparam ERR_CNT_W=8;
  - the default NCH.
- One sub-module, demux_dec: combinational SEL_W-to-NCH one-hot decoder, gated by an enable.
  - Produces the per-slot shadow write enables. It is the inverse of MUX8_1's select.
  - The top level contains the FSM, slot counter, shadow/dout registers and pulses.

Test Plan:
- WIDTH=1, NCH=8. After rst, send frame_start plus 8 samples 0,1,0,1,0,1,0,1 back-to-back -> one frame_done on slot 7; dout=8'b10101010; locked=1 from slot 0.
- HUNT discard: 3 valid samples without frame_start, then a full frame of 1,1,1,1,0,0,0,0 -> samples before the marker ignored; dout=8'b00001111.
- Short frame: frame_start, 5 samples, then frame_start again -> sync_err pulse; dout unchanged; the following full frame completes normally.
- Missing marker: after a complete frame, the next sample arrives without frame_start -> sync_err; locked=0; state HUNT.
- Gaps: din_valid toggled 1/0 through a frame -> same dout as back-to-back; sel holds during gaps.
- rst asserted at slot 4 -> dout=0, sel=0, locked=0 asynchronously. With TDM_DEMUX_ERR_CNT_EN: 300 short frames -> err_cnt=8'hFF.

Source files
------------

// File: rtl/tdm_pkg.sv
// tdm_pkg: shared definitions for the TDM receive demultiplexer.
//   state_e     - frame alignment FSM encoding (hunting vs. locked to frames)
//   ERR_CNT_W   - width of the optional sync error counter
//   NCH_DEFAULT - default number of slots per frame
package tdm_pkg;

  typedef enum logic {
    StHunt   = 1'b0,
    StLocked = 1'b1
  } state_e;

  localparam int unsigned ERR_CNT_W   = 8;
  localparam int unsigned NCH_DEFAULT = 8;

endpackage

// File: rtl/tdm_demux8_dec.sv
// demux_dec: SEL_W-to-NCH one-hot decoder gated by an enable. Produces the
// per-slot shadow write strobes for the receive demultiplexer.
// Ports:
//   sel    in  SEL_W  slot index to decode
//   en     in  1      all outputs low when deasserted
//   onehot out NCH    bit k high when en && sel == k
module demux_dec #(
  parameter int unsigned NCH   = 8,
  parameter int unsigned SEL_W = $clog2(NCH)
) (
  input  logic [SEL_W-1:0] sel,
  input  logic             en,
  output logic [NCH-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) begin
      onehot[sel] = 1'b1;
    end
  end

endmodule

// File: rtl/tdm_demux8.sv
// tdm_demux8: receive end of a TDM serial channel. Each valid sample is steered
// into a per-slot shadow register by an internal slot counter; a complete frame
// is copied to dout in one step so dout never shows a partial frame.
// Optional feature: define TDM_DEMUX_ERR_CNT_EN to add a saturating 8-bit
// sync error counter on port err_cnt.
// Ports:
//   clk         in  1          rising-edge clock
//   rst         in  1          asynchronous active-high reset
//   din         in  WIDTH      sample for the current slot
//   din_valid   in  1          din carries a sample this cycle
//   frame_start in  1          sample is slot 0 of a new frame (qualified by din_valid)
//   dout        out NCH*WIDTH  last complete frame, channel k at [k*WIDTH +: WIDTH]
//   frame_done  out 1          pulse: dout updated
//   sync_err    out 1          pulse: framing error (short frame or missing marker)
//   locked      out 1          aligned to frames
//   sel         out SEL_W      slot the next valid sample goes to
//   err_cnt     out 8          saturating sync error count (TDM_DEMUX_ERR_CNT_EN only)
module tdm_demux8
  import tdm_pkg::*;
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned NCH   = NCH_DEFAULT,
  parameter int unsigned SEL_W = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     din,
  input  logic                 din_valid,
  input  logic                 frame_start,
  output logic [NCH*WIDTH-1:0] dout,
  output logic                 frame_done,
  output logic                 sync_err,
  output logic                 locked,
`ifdef TDM_DEMUX_ERR_CNT_EN
  output logic [ERR_CNT_W-1:0] err_cnt,
`endif
  output logic [SEL_W-1:0]     sel
);

  state_e                 state_q, state_d;
  logic [SEL_W-1:0]       sel_q, sel_d;
  logic [WIDTH-1:0]       shadow_q [NCH];
  logic [NCH*WIDTH-1:0]   dout_q, dout_next;
  logic                   frame_done_q, frame_done_d;
  logic                   sync_err_q, sync_err_d;
  logic                   wr_en, load_dout;
  logic [SEL_W-1:0]       wr_sel;
  logic [NCH-1:0]         wr_onehot;

  // A marker always lands in slot 0, whatever the counter says.
  assign wr_sel = frame_start ? '0 : sel_q;

  demux_dec #(
    .NCH   (NCH),
    .SEL_W (SEL_W)
  ) u_dec (
    .sel    (wr_sel),
    .en     (wr_en),
    .onehot (wr_onehot)
  );

  // Final slot bypasses the shadow so the frame is published on the same edge.
  always_comb begin
    dout_next = '0;
    for (int k = 0; k < NCH - 1; k++) begin
      dout_next[k*WIDTH +: WIDTH] = shadow_q[k];
    end
    dout_next[(NCH-1)*WIDTH +: WIDTH] = din;
  end

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    wr_en        = 1'b0;
    load_dout    = 1'b0;
    frame_done_d = 1'b0;
    sync_err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        StHunt: begin
          if (frame_start) begin
            wr_en   = 1'b1;
            sel_d   = SEL_W'(1);
            state_d = StLocked;
          end
        end
        StLocked: begin
          if (frame_start) begin
            // Marker mid-frame: drop the partial frame and restart.
            sync_err_d = (sel_q != '0);
            wr_en      = 1'b1;
            sel_d      = SEL_W'(1);
          end else if (sel_q == '0) begin
            // Frame finished but no marker followed: lost alignment.
            sync_err_d = 1'b1;
            state_d    = StHunt;
          end else begin
            wr_en = 1'b1;
            sel_d = sel_q + SEL_W'(1);
            if (sel_q == SEL_W'(NCH - 1)) begin
              load_dout    = 1'b1;
              frame_done_d = 1'b1;
            end
          end
        end
        default: state_d = StHunt;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StHunt;
      sel_q        <= '0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      sync_err_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        shadow_q[k] <= '0;
      end
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      frame_done_q <= frame_done_d;
      sync_err_q   <= sync_err_d;
      if (load_dout) begin
        dout_q <= dout_next;
      end
      for (int k = 0; k < NCH; k++) begin
        if (wr_onehot[k]) begin
          shadow_q[k] <= din;
        end
      end
    end
  end

`ifdef TDM_DEMUX_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if (sync_err_d && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  assign dout       = dout_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;
  assign locked     = (state_q == StLocked);
  assign sel        = sel_q;

endmodule
